// File: rtl/rr_arb8_enc_pkg.sv
// Shared arbiter definitions: FSM state encoding and requester geometry.
package pkg_arb;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb8_enc_pick8.sv
// Rotating-priority pick: the first set request at or after ptr, wrapping 7->0.
module rr_pick8
    import pkg_arb::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        winner = ptr + off;
        any    = |req;
    end

endmodule

// File: rtl/rr_arb8_enc.sv
// 8-way round-robin arbiter with grant hold, timeout and encoded grant output.
module rr_arb8_enc
    import pkg_arb::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_en,
    output logic             tmo
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] idx_n;
    logic [7:0]       cnt, cnt_n;
    logic             tmo_n;
    logic [IDX_W-1:0] win;
    logic             any;
    logic             rel_a, rel_b, rel_c;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .any    (any)
    );

    // Next-state logic: arbitrate in IDLE, watch the release conditions in GRANT.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        cnt_n   = cnt;
        tmo_n   = 1'b0;
        rel_a   = done;
        rel_b   = ~req[gnt_idx];
        rel_c   = (HOLD_LIM != 8'd0) && (cnt == HOLD_LIM);
        case (state)
            IDLE: begin
                if (any) begin
                    idx_n   = win;
                    cnt_n   = 8'd1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (rel_a || rel_b || rel_c) begin
                    // Move priority past the holder so it cannot starve others.
                    ptr_n   = gnt_idx + 3'd1;
                    state_n = IDLE;
                    tmo_n   = rel_c && !rel_a && !rel_b;
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset wins over any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_idx <= '0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt_idx <= idx_n;
            tmo     <= tmo_n;
        end
    end

    // The enable is the registered GRANT state itself.
    assign gnt_en = (state == GRANT);

endmodule
